pa_fpu_wb_arb: RTL and testbench
================================

# pa_fpu_wb_arb

Writeback arbiter for the FPU result bus. It shares the single FPU register-file write port between the pipelined datapath (EX2 results) and the iterative divide/sqrt unit (FDSU). It registers the winner into a one-entry output stage, stalls or holds the losing source, and accumulates sticky fflags for the CSR. It sits between the FPU execution units and the FP register file / IDU forwarding network.

## Interface
- DATA_W, 32, result data width
- FLAG_W, 5, fflags width
- RD_W, 5, destination register index width
- cpuclk  in  1  clock, rising edge
- cpurst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; discards the output stage
- dp_ex2_req  in  1  datapath EX2 result valid
- dp_ex2_data / dp_ex2_fflags / dp_ex2_rd  in  DATA_W / FLAG_W / RD_W  datapath result payload
- dp_ex2_stall  out  1  datapath must hold EX2 this cycle
- fdsu_wb_vld  in  1  FDSU result valid; held until acked
- fdsu_wb_data / fdsu_wb_fflags / fdsu_wb_rd  in  DATA_W / FLAG_W / RD_W  FDSU result payload
- fdsu_wb_ack  out  1  FDSU result accepted this cycle
- wb_vld  out  1  register-file write request
- wb_data / wb_fflags / wb_rd  out  DATA_W / FLAG_W / RD_W  write payload
- wb_rdy  in  1  register file accepts the write
- csr_fflags_wen  in  1  CSR write to fflags
- csr_fflags_wdata  in  FLAG_W  CSR write value
- fflags_acc  out  FLAG_W  sticky accumulated fflags
- fwd_vld / fwd_data / fwd_rd  out  1 / DATA_W / RD_W  IDU forwarding port

## Operation
- load_en = ~wb_vld | wb_rdy. No grant is issued when load_en=0 or flush=1.
- Single request with load_en: that source is granted.
- Conflict (both requesting, load_en): round-robin. The source not granted at the previous conflict wins. The pointer updates only on a conflict grant. Reset pointer favours FDSU.
- dp_ex2_stall = dp_ex2_req & ~dp_grant. fdsu_wb_ack = fdsu_wb_vld & fdsu_grant. Both are combinational.
- A grant loads the payload into the output stage and sets wb_vld.
- wb_vld & wb_rdy with no new grant clears wb_vld.
- flush clears wb_vld the same edge and overrides any load. No ack or grant is issued in a flush cycle; dp_ex2_stall is 0 under flush.
- fflags_acc update:
  - On a handshake (wb_vld & wb_rdy & ~flush): fflags_acc |= wb_fflags.
  - csr_fflags_wen takes priority: fflags_acc = csr_fflags_wdata | (handshake ? wb_fflags : 0).
  - fflags_acc is not affected by flush.
- Output payload is don't-care while wb_vld=0. It holds its value (no toggling) while wb_vld=1 & ~wb_rdy.

## Timing
- Reset values: wb_vld=0, wb_data=0, wb_fflags=0, wb_rd=0, fflags_acc=0, fwd_vld=0, RR pointer=FDSU, dp_ex2_stall=0, fdsu_wb_ack=0.
- Latency: request granted in cycle N appears on wb_* in N+1.
- Throughput: 1 result/cycle while wb_rdy=1.
- Back-pressure: wb_rdy=0 with wb_vld=1 stalls all grants. A datapath request sees dp_ex2_stall=1 for every such cycle.
- Reset asserted mid-transfer: the output stage empties immediately, and a pending FDSU result is not acked.

## Configuration
- PA_FPU_WB_FWD_EN defined: fwd_vld=wb_vld & ~flush, fwd_data=wb_data, fwd_rd=wb_rd. This lets the IDU bypass while the write waits on wb_rdy.
- Undefined: fwd_vld, fwd_data and fwd_rd are tied to 0. All other behaviour is unchanged.

## Structure
- Package pa_fpu_wb_pkg:
  - Width constants DATA_W, FLAG_W, RD_W.
  - Source enum wb_src_e {SRC_DP, SRC_FDSU}.
  - Payload struct wb_payload_t {data, fflags, rd}.
- Sub-module pa_fpu_wb_rr: 2-way round-robin picker. Inputs are requests, enable and conflict; it holds the pointer flop and outputs one-hot grants.
- The top level holds the output stage, the fflags accumulator and the forwarding logic.

## Test plan
- Reset, then a single DP request (data=0x3F800000, rd=3, fflags=0) with wb_rdy=1 → dp_ex2_stall=0. Next cycle: wb_vld=1, wb_data=0x3F800000, wb_rd=3.
- DP and FDSU request in the same cycle after reset → FDSU acked, dp_ex2_stall=1. The next cycle grants DP. At the following conflict the pointer grants FDSU, so the winner alternates.
- wb_vld=1 with wb_rdy=0 for 3 cycles, DP requesting → stall=1 for 3 cycles and wb_data stable. DP is granted in the cycle wb_rdy rises.
- Handshakes with fflags 0x01 then 0x10 → fflags_acc=0x11. csr_fflags_wen with wdata=0x04 in the same cycle as a handshake with fflags 0x02 → fflags_acc=0x06.
- flush while wb_vld=1 and FDSU requesting → wb_vld=0 next cycle, fdsu_wb_ack=0 in the flush cycle, fflags_acc unchanged.
- With PA_FPU_WB_FWD_EN defined: fwd_* mirrors wb_* during back-pressure. With it undefined: fwd_vld stays 0 through all the scenarios above.

Source files
------------

// File: rtl/pa_fpu_wb_pkg.sv
// Shared widths, source encoding and payload type for the FPU writeback arbiter.
package pa_fpu_wb_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 5;
  localparam int RD_W   = 5;

  typedef enum logic {
    SRC_DP   = 1'b0,
    SRC_FDSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] fflags;
    logic [RD_W-1:0]   rd;
  } wb_payload_t;

endpackage

// File: rtl/pa_fpu_wb_arb_if.sv
// Bus bundle between the FPU result sources, the FP register file, CSR and IDU forwarding.
interface pa_fpu_wb_arb_if
  import pa_fpu_wb_pkg::*;
();

  logic              dp_ex2_req;
  logic [DATA_W-1:0] dp_ex2_data;
  logic [FLAG_W-1:0] dp_ex2_fflags;
  logic [RD_W-1:0]   dp_ex2_rd;
  logic              dp_ex2_stall;

  logic              fdsu_wb_vld;
  logic [DATA_W-1:0] fdsu_wb_data;
  logic [FLAG_W-1:0] fdsu_wb_fflags;
  logic [RD_W-1:0]   fdsu_wb_rd;
  logic              fdsu_wb_ack;

  logic              wb_vld;
  logic [DATA_W-1:0] wb_data;
  logic [FLAG_W-1:0] wb_fflags;
  logic [RD_W-1:0]   wb_rd;
  logic              wb_rdy;

  logic              flush;
  logic              csr_fflags_wen;
  logic [FLAG_W-1:0] csr_fflags_wdata;
  logic [FLAG_W-1:0] fflags_acc;

  logic              fwd_vld;
  logic [DATA_W-1:0] fwd_data;
  logic [RD_W-1:0]   fwd_rd;

  modport slave (
    input  dp_ex2_req, dp_ex2_data, dp_ex2_fflags, dp_ex2_rd,
    output dp_ex2_stall,
    input  fdsu_wb_vld, fdsu_wb_data, fdsu_wb_fflags, fdsu_wb_rd,
    output fdsu_wb_ack,
    output wb_vld, wb_data, wb_fflags, wb_rd,
    input  wb_rdy,
    input  flush, csr_fflags_wen, csr_fflags_wdata,
    output fflags_acc,
    output fwd_vld, fwd_data, fwd_rd
  );

  modport master (
    output dp_ex2_req, dp_ex2_data, dp_ex2_fflags, dp_ex2_rd,
    input  dp_ex2_stall,
    output fdsu_wb_vld, fdsu_wb_data, fdsu_wb_fflags, fdsu_wb_rd,
    input  fdsu_wb_ack,
    input  wb_vld, wb_data, wb_fflags, wb_rd,
    output wb_rdy,
    output flush, csr_fflags_wen, csr_fflags_wdata,
    input  fflags_acc,
    input  fwd_vld, fwd_data, fwd_rd
  );

endinterface

// File: rtl/pa_fpu_wb_rr.sv
// Two-way round-robin picker; the pointer names the source that wins the next conflict.
module pa_fpu_wb_rr
  import pa_fpu_wb_pkg::*;
(
  input  logic cpuclk,
  input  logic cpurst,
  input  logic req_dp,
  input  logic req_fdsu,
  input  logic en,
  input  logic conflict,
  output logic gnt_dp,
  output logic gnt_fdsu
);

  wb_src_e ptr_q, ptr_d;

  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) ptr_q <= SRC_FDSU;
    else        ptr_q <= ptr_d;
  end

  // Pointer moves only when a conflict was actually resolved, handing priority to the loser.
  always_comb begin
    ptr_d    = ptr_q;
    gnt_dp   = 1'b0;
    gnt_fdsu = 1'b0;
    if (en) begin
      gnt_dp   = req_dp   & (~req_fdsu | (ptr_q == SRC_DP));
      gnt_fdsu = req_fdsu & (~req_dp   | (ptr_q == SRC_FDSU));
      if (conflict)
        ptr_d = (ptr_q == SRC_FDSU) ? SRC_DP : SRC_FDSU;
    end
  end

endmodule

// File: rtl/pa_fpu_wb_arb.sv
// FPU writeback arbiter: one-entry output stage, sticky fflags and optional IDU forwarding.
// Define PA_FPU_WB_FWD_EN to drive the forwarding port from the output stage.
module pa_fpu_wb_arb
  import pa_fpu_wb_pkg::*;
(
  input  logic            cpuclk,
  input  logic            cpurst,
  pa_fpu_wb_arb_if.slave  bus
);

  logic        load_en, grant_en, conflict, dp_grant, fdsu_grant, handshake;
  logic        vld_q;
  wb_payload_t stage_q;
  logic [FLAG_W-1:0] acc_q;

  // Reset gates grants so a held FDSU result is never acked while the block is in reset.
  assign load_en   = ~vld_q | bus.wb_rdy;
  assign grant_en  = load_en & ~bus.flush & ~cpurst;
  assign conflict  = bus.dp_ex2_req & bus.fdsu_wb_vld;
  assign handshake = vld_q & bus.wb_rdy & ~bus.flush;

  pa_fpu_wb_rr u_rr (
    .cpuclk   (cpuclk),
    .cpurst   (cpurst),
    .req_dp   (bus.dp_ex2_req),
    .req_fdsu (bus.fdsu_wb_vld),
    .en       (grant_en),
    .conflict (conflict),
    .gnt_dp   (dp_grant),
    .gnt_fdsu (fdsu_grant)
  );

  assign bus.dp_ex2_stall = bus.dp_ex2_req & ~dp_grant & ~bus.flush & ~cpurst;
  assign bus.fdsu_wb_ack  = bus.fdsu_wb_vld & fdsu_grant;

  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      vld_q   <= 1'b0;
      stage_q <= '0;
    end else if (bus.flush) begin
      vld_q   <= 1'b0;
    end else if (dp_grant) begin
      vld_q   <= 1'b1;
      stage_q <= '{data: bus.dp_ex2_data, fflags: bus.dp_ex2_fflags, rd: bus.dp_ex2_rd};
    end else if (fdsu_grant) begin
      vld_q   <= 1'b1;
      stage_q <= '{data: bus.fdsu_wb_data, fflags: bus.fdsu_wb_fflags, rd: bus.fdsu_wb_rd};
    end else if (bus.wb_rdy) begin
      vld_q   <= 1'b0;
    end
  end

  // A CSR write replaces the sticky flags but still folds in a retiring result's flags.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst)
      acc_q <= '0;
    else if (bus.csr_fflags_wen)
      acc_q <= bus.csr_fflags_wdata | (handshake ? stage_q.fflags : '0);
    else if (handshake)
      acc_q <= acc_q | stage_q.fflags;
  end

  assign bus.wb_vld     = vld_q;
  assign bus.wb_data    = stage_q.data;
  assign bus.wb_fflags  = stage_q.fflags;
  assign bus.wb_rd      = stage_q.rd;
  assign bus.fflags_acc = acc_q;

`ifdef PA_FPU_WB_FWD_EN
  assign bus.fwd_vld  = vld_q & ~bus.flush;
  assign bus.fwd_data = stage_q.data;
  assign bus.fwd_rd   = stage_q.rd;
`else
  assign bus.fwd_vld  = 1'b0;
  assign bus.fwd_data = '0;
  assign bus.fwd_rd   = '0;
`endif

endmodule

// File: tb/tb_pa_fpu_wb_arb.sv
// Directed self-checking bench for pa_fpu_wb_arb; honours PA_FPU_WB_FWD_EN for fwd_* expectations.
module tb_pa_fpu_wb_arb;
  import pa_fpu_wb_pkg::*;

`ifdef PA_FPU_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic cpuclk = 1'b0;
  logic cpurst;
  int   tests_run = 0;
  int   tests_failed = 0;

  pa_fpu_wb_arb_if bus ();

  pa_fpu_wb_arb dut (
    .cpuclk (cpuclk),
    .cpurst (cpurst),
    .bus    (bus)
  );

  always #5 cpuclk = ~cpuclk;

  task automatic tick();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dp_ex2_req = 0; bus.dp_ex2_data = '0; bus.dp_ex2_fflags = '0; bus.dp_ex2_rd = '0;
    bus.fdsu_wb_vld = 0; bus.fdsu_wb_data = '0; bus.fdsu_wb_fflags = '0; bus.fdsu_wb_rd = '0;
    bus.wb_rdy = 1; bus.flush = 0; bus.csr_fflags_wen = 0; bus.csr_fflags_wdata = '0;
  endtask

  task automatic drive_dp(input logic [31:0] d, input logic [4:0] f, input logic [4:0] r);
    bus.dp_ex2_req = 1; bus.dp_ex2_data = d; bus.dp_ex2_fflags = f; bus.dp_ex2_rd = r;
  endtask

  task automatic drive_fdsu(input logic [31:0] d, input logic [4:0] f, input logic [4:0] r);
    bus.fdsu_wb_vld = 1; bus.fdsu_wb_data = d; bus.fdsu_wb_fflags = f; bus.fdsu_wb_rd = r;
  endtask

  task automatic test_reset();
    clear_inputs();
    cpurst = 1;
    drive_dp(32'h1111_1111, 5'h1, 5'd1);
    drive_fdsu(32'h2222_2222, 5'h2, 5'd2);
    tick(); tick();
    tests_run++;
    if (bus.wb_vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wb_vld: got %b expected 0", bus.wb_vld); end
    tests_run++;
    if (bus.wb_data !== 32'h0 || bus.wb_rd !== 5'h0 || bus.wb_fflags !== 5'h0) begin
      tests_failed++; $display("[TB] FAIL reset_payload: got %h/%h/%h expected 0/0/0", bus.wb_data, bus.wb_rd, bus.wb_fflags);
    end
    tests_run++;
    if (bus.fflags_acc !== 5'h0) begin tests_failed++; $display("[TB] FAIL reset_acc: got %h expected 00", bus.fflags_acc); end
    tests_run++;
    if (bus.dp_ex2_stall !== 1'b0 || bus.fdsu_wb_ack !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_stall_ack: got %b/%b expected 0/0", bus.dp_ex2_stall, bus.fdsu_wb_ack);
    end
    tests_run++;
    if (bus.fwd_vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fwd_vld: got %b expected 0", bus.fwd_vld); end
    clear_inputs();
    cpurst = 0;
    tick();
  endtask

  task automatic test_single_dp();
    drive_dp(32'h3F80_0000, 5'h0, 5'd3);
    #1;
    tests_run++;
    if (bus.dp_ex2_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_stall: got %b expected 0", bus.dp_ex2_stall); end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus.wb_vld !== 1'b1 || bus.wb_data !== 32'h3F80_0000 || bus.wb_rd !== 5'd3) begin
      tests_failed++; $display("[TB] FAIL single_wb: got vld=%b data=%h rd=%0d expected vld=1 data=3f800000 rd=3", bus.wb_vld, bus.wb_data, bus.wb_rd);
    end
    tests_run++;
    if (bus.fwd_vld !== FWD) begin tests_failed++; $display("[TB] FAIL single_fwd_vld: got %b expected %b", bus.fwd_vld, FWD); end
    tick();
    tests_run++;
    if (bus.wb_vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_drain: got %b expected 0", bus.wb_vld); end
  endtask

  task automatic test_conflict();
    logic [31:0] exp_data [3];
    logic [2:0]  exp_ack, exp_stall;
    exp_data = '{32'hB000_0001, 32'hA000_0001, 32'hC000_0001};
    exp_ack   = 3'b101;
    exp_stall = 3'b101;
    drive_dp(32'hA000_0001, 5'h0, 5'd4);
    drive_fdsu(32'hB000_0001, 5'h0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (bus.fdsu_wb_ack !== exp_ack[i] || bus.dp_ex2_stall !== exp_stall[i]) begin
        tests_failed++; $display("[TB] FAIL conflict_grant_%0d: got ack=%b stall=%b expected ack=%b stall=%b", i, bus.fdsu_wb_ack, bus.dp_ex2_stall, exp_ack[i], exp_stall[i]);
      end
      tick();
      tests_run++;
      if (bus.wb_vld !== 1'b1 || bus.wb_data !== exp_data[i]) begin
        tests_failed++; $display("[TB] FAIL conflict_wb_%0d: got vld=%b data=%h expected vld=1 data=%h", i, bus.wb_vld, bus.wb_data, exp_data[i]);
      end
      if (i == 0) drive_fdsu(32'hC000_0001, 5'h0, 5'd6);
      if (i == 1) drive_dp(32'hD000_0001, 5'h0, 5'd7);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_pressure();
    bus.wb_rdy = 0;
    drive_dp(32'hE000_0001, 5'h0, 5'd8);
    tick();
    drive_dp(32'hF000_0001, 5'h0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (bus.dp_ex2_stall !== 1'b1 || bus.wb_vld !== 1'b1 || bus.wb_data !== 32'hE000_0001) begin
        tests_failed++; $display("[TB] FAIL bp_hold_%0d: got stall=%b vld=%b data=%h expected stall=1 vld=1 data=e0000001", i, bus.dp_ex2_stall, bus.wb_vld, bus.wb_data);
      end
      tests_run++;
      if (bus.fwd_vld !== FWD || bus.fwd_data !== (FWD ? 32'hE000_0001 : 32'h0) || bus.fwd_rd !== (FWD ? 5'd8 : 5'd0)) begin
        tests_failed++; $display("[TB] FAIL bp_fwd_%0d: got vld=%b data=%h rd=%0d expected fwd_en=%b", i, bus.fwd_vld, bus.fwd_data, bus.fwd_rd, FWD);
      end
      tick();
    end
    bus.wb_rdy = 1;
    #1;
    tests_run++;
    if (bus.dp_ex2_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release_stall: got %b expected 0", bus.dp_ex2_stall); end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus.wb_vld !== 1'b1 || bus.wb_data !== 32'hF000_0001) begin
      tests_failed++; $display("[TB] FAIL bp_release_wb: got vld=%b data=%h expected vld=1 data=f0000001", bus.wb_vld, bus.wb_data);
    end
    tick();
  endtask

  task automatic test_fflags();
    drive_dp(32'h1, 5'h01, 5'd1);
    tick();
    drive_dp(32'h2, 5'h10, 5'd2);
    tick();
    clear_inputs();
    tests_run++;
    if (bus.fflags_acc !== 5'h01) begin tests_failed++; $display("[TB] FAIL acc_first: got %h expected 01", bus.fflags_acc); end
    tick();
    tests_run++;
    if (bus.fflags_acc !== 5'h11) begin tests_failed++; $display("[TB] FAIL acc_sticky: got %h expected 11", bus.fflags_acc); end
    drive_dp(32'h3, 5'h02, 5'd3);
    tick();
    clear_inputs();
    bus.csr_fflags_wen = 1;
    bus.csr_fflags_wdata = 5'h04;
    tick();
    clear_inputs();
    tests_run++;
    if (bus.fflags_acc !== 5'h06) begin tests_failed++; $display("[TB] FAIL acc_csr_merge: got %h expected 06", bus.fflags_acc); end
  endtask

  task automatic test_flush();
    bus.wb_rdy = 0;
    drive_dp(32'h7777_0000, 5'h08, 5'd10);
    tick();
    clear_inputs();
    bus.flush = 1;
    drive_fdsu(32'h8888_0000, 5'h0, 5'd11);
    #1;
    tests_run++;
    if (bus.fdsu_wb_ack !== 1'b0 || bus.dp_ex2_stall !== 1'b0 || bus.fwd_vld !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL flush_cycle: got ack=%b stall=%b fwd=%b expected 0/0/0", bus.fdsu_wb_ack, bus.dp_ex2_stall, bus.fwd_vld);
    end
    tick();
    bus.flush = 0;
    tests_run++;
    if (bus.wb_vld !== 1'b0 || bus.fflags_acc !== 5'h06) begin
      tests_failed++; $display("[TB] FAIL flush_result: got vld=%b acc=%h expected vld=0 acc=06", bus.wb_vld, bus.fflags_acc);
    end
    #1;
    tests_run++;
    if (bus.fdsu_wb_ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_after_ack: got %b expected 1", bus.fdsu_wb_ack); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.wb_rdy = 0;
    drive_dp(32'h9999_0000, 5'h0, 5'd12);
    tick();
    clear_inputs();
    bus.wb_rdy = 0;
    drive_fdsu(32'hAAAA_0000, 5'h0, 5'd13);
    #2;
    cpurst = 1;
    #1;
    tests_run++;
    if (bus.wb_vld !== 1'b0 || bus.fdsu_wb_ack !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_mid: got vld=%b ack=%b expected 0/0", bus.wb_vld, bus.fdsu_wb_ack);
    end
    tick();
    clear_inputs();
    cpurst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_dp();
    test_conflict();
    test_back_pressure();
    test_fflags();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
